// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared definitions for the multi-cycle data memory responder:
//   - RISC-V funct3 codes for the load/store family
//   - FSM state encodings (IDLE / WAIT / RESPOND)
//   - memory access width codes (byte / half / word)
//   - the captured-request record and a funct3 -> width helper
// No ports (package).
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] STATE_IDLE    = 2'b00;
   localparam logic [1:0] STATE_WAIT    = 2'b01;
   localparam logic [1:0] STATE_RESPOND = 2'b10;

   localparam logic [1:0] MEM_MODE_BYTE = 2'b00;
   localparam logic [1:0] MEM_MODE_HALF = 2'b01;
   localparam logic [1:0] MEM_MODE_WORD = 2'b10;

   localparam int COUNT_WIDTH = 4;

   typedef struct packed {
      logic        write;
      logic [31:0] address;
      logic [31:0] data;
      logic [2:0]  funct3;
   } mem_req_t;

   // Access width is encoded in the two low funct3 bits for every legal
   // load/store; 2'b11 never reaches memory because it is flagged illegal.
   function automatic logic [1:0] funct3ToMode(input logic [2:0] funct3);
      logic [1:0] mode;
      case (funct3[1:0])
         2'b00:   mode = MEM_MODE_BYTE;
         2'b01:   mode = MEM_MODE_HALF;
         default: mode = MEM_MODE_WORD;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/data_memory_responder_load_store_aligner.sv
// ---------------------------------------------------------------------------
// load_store_aligner
// Purely combinational lane steering for the data memory responder.
// Ports:
//   i_write       1  request is a store
//   i_funct3      3  RISC-V funct3 of the access
//   i_byteOffset  2  address[1:0]
//   i_storeData  32  store value, lane-aligned at the LSBs
//   i_readWord   32  word currently held at the addressed location
//   o_byteEnable  4  byte lanes a store would write
//   o_storeData  32  store value replicated onto every candidate lane
//   o_loadData   32  extracted and sign/zero-extended load result
//   o_misaligned 1  half not on a 2-byte boundary or word not on 4-byte
//   o_illegal    1  funct3 is not a legal load/store encoding
// ---------------------------------------------------------------------------
module load_store_aligner
   import data_memory_responder_pkg::*;
(
   input  logic        i_write,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_byteOffset,
   input  logic [31:0] i_storeData,
   input  logic [31:0] i_readWord,
   output logic [3:0]  o_byteEnable,
   output logic [31:0] o_storeData,
   output logic [31:0] o_loadData,
   output logic        o_misaligned,
   output logic        o_illegal
);

   logic [1:0]  w_mode;
   logic [7:0]  w_loadByte;
   logic [15:0] w_loadHalf;

   assign w_mode = funct3ToMode(i_funct3);

   // Loads accept 000/001/010/100/101; stores accept only 000/001/010.
   always_comb begin
      if (i_write) begin
         o_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
      end else begin
         o_illegal = (i_funct3[1:0] == 2'b11) | (i_funct3 == 3'b110);
      end
      o_misaligned = ((w_mode == MEM_MODE_HALF) & i_byteOffset[0]) |
                     ((w_mode == MEM_MODE_WORD) & (i_byteOffset != 2'b00));
   end

   // Stores replicate the low byte/half onto every lane so the byte enables
   // alone decide which lanes of the word actually change.
   always_comb begin
      o_byteEnable = 4'b0000;
      o_storeData  = 32'h0000_0000;
      case (w_mode)
         MEM_MODE_BYTE: begin
            o_byteEnable = 4'b0001 << i_byteOffset;
            o_storeData  = {4{i_storeData[7:0]}};
         end
         MEM_MODE_HALF: begin
            o_byteEnable = i_byteOffset[1] ? 4'b1100 : 4'b0011;
            o_storeData  = {2{i_storeData[15:0]}};
         end
         MEM_MODE_WORD: begin
            o_byteEnable = 4'b1111;
            o_storeData  = i_storeData;
         end
         default: begin
            o_byteEnable = 4'b0000;
            o_storeData  = 32'h0000_0000;
         end
      endcase
   end

   // Little-endian lane extraction; funct3[2] selects zero extension.
   always_comb begin
      case (i_byteOffset)
         2'b00:   w_loadByte = i_readWord[7:0];
         2'b01:   w_loadByte = i_readWord[15:8];
         2'b10:   w_loadByte = i_readWord[23:16];
         default: w_loadByte = i_readWord[31:24];
      endcase
      w_loadHalf = i_byteOffset[1] ? i_readWord[31:16] : i_readWord[15:0];
      case (w_mode)
         MEM_MODE_BYTE: o_loadData = i_funct3[2] ? {24'h000000, w_loadByte}
                                                 : {{24{w_loadByte[7]}}, w_loadByte};
         MEM_MODE_HALF: o_loadData = i_funct3[2] ? {16'h0000, w_loadHalf}
                                                 : {{16{w_loadHalf[15]}}, w_loadHalf};
         MEM_MODE_WORD: o_loadData = i_readWord;
         default:       o_loadData = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Memory-side responder for the core's load/store port. One request is
// accepted per valid/ready handshake, the array is accessed WAIT_STATES+1
// cycles later, and the result is held on a second valid/ready handshake.
// Ports:
//   clk_i          in   1  clock, all state on the rising edge
//   reset_i        in   1  synchronous active-high reset
//   req_valid_i    in   1  request present
//   req_ready_o    out  1  high only in IDLE
//   req_write_i    in   1  1 = store, 0 = load
//   req_address_i  in  32  byte address
//   req_data_i     in  32  store data, lane-aligned at the LSBs
//   req_funct3_i   in   3  RISC-V funct3
//   rsp_valid_o    out  1  response present
//   rsp_ready_i    in   1  initiator takes the response
//   rsp_data_o     out 32  load result (0 for stores and errors)
//   rsp_error_o    out  1  request rejected, memory untouched
//   busy_o         out  1  state is not IDLE
// ---------------------------------------------------------------------------
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    WAIT_STATES = 2,
   parameter string INIT_FILE   = ""
)
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_address_i,
   input  logic [31:0] req_data_i,
   input  logic [2:0]  req_funct3_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_error_o,
   output logic        busy_o
);

   localparam int                     ADDR_BITS   = $clog2(DEPTH_WORDS);
   localparam logic [31:0]            DEPTH_LIMIT = 32'(DEPTH_WORDS);
   localparam logic [COUNT_WIDTH-1:0] WAIT_LOAD   = COUNT_WIDTH'(WAIT_STATES);

   // The wait counter is only four bits wide.
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_badWaitStates
      $error("data_memory_responder: WAIT_STATES must be 0..15");
   end

   // Image preload belongs to the memory-initialisation flow of the target,
   // not to this RTL; flag it so a non-empty image is never silently lost.
   if (INIT_FILE != "") begin : g_initFileNotice
      $warning("data_memory_responder: INIT_FILE must be loaded by the memory init flow");
   end

   logic [1:0]             r_state;
   logic [COUNT_WIDTH-1:0] r_count;
   mem_req_t               r_req;
   logic [31:0]            r_rspData;
   logic                   r_rspError;
   logic [31:0]            r_mem [DEPTH_WORDS];

   logic [ADDR_BITS-1:0] w_wordIndex;
   logic [31:0]          w_readWord;
   logic [3:0]           w_byteEnable;
   logic [31:0]          w_storeData;
   logic [31:0]          w_loadData;
   logic                 w_misaligned;
   logic                 w_illegal;
   logic                 w_outOfRange;
   logic                 w_error;
   logic                 w_access;
   logic                 w_commitStore;

   assign w_wordIndex  = r_req.address[ADDR_BITS+1:2];
   assign w_readWord   = r_mem[w_wordIndex];
   assign w_outOfRange = {2'b00, r_req.address[31:2]} >= DEPTH_LIMIT;
   assign w_error      = w_misaligned | w_illegal | w_outOfRange;
   assign w_access     = (r_state == STATE_WAIT) && (r_count == '0);
   // A reset landing on the access edge aborts the store as well.
   assign w_commitStore = w_access & r_req.write & ~w_error & ~reset_i;

   assign req_ready_o = (r_state == STATE_IDLE);
   assign rsp_valid_o = (r_state == STATE_RESPOND);
   assign busy_o      = (r_state != STATE_IDLE);
   assign rsp_data_o  = r_rspData;
   assign rsp_error_o = r_rspError;

   load_store_aligner u_aligner (
      .i_write      (r_req.write),
      .i_funct3     (r_req.funct3),
      .i_byteOffset (r_req.address[1:0]),
      .i_storeData  (r_req.data),
      .i_readWord   (w_readWord),
      .o_byteEnable (w_byteEnable),
      .o_storeData  (w_storeData),
      .o_loadData   (w_loadData),
      .o_misaligned (w_misaligned),
      .o_illegal    (w_illegal)
   );

   // Handshake FSM: capture the request in IDLE, count down the wait
   // states, perform the access when the counter reaches zero, then hold
   // the response until the initiator takes it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= STATE_IDLE;
         r_count    <= '0;
         r_req      <= '0;
         r_rspData  <= 32'h0000_0000;
         r_rspError <= 1'b0;
      end else begin
         case (r_state)
            STATE_IDLE: begin
               if (req_valid_i) begin
                  r_req.write   <= req_write_i;
                  r_req.address <= req_address_i;
                  r_req.data    <= req_data_i;
                  r_req.funct3  <= req_funct3_i;
                  r_count       <= WAIT_LOAD;
                  r_state       <= STATE_WAIT;
               end
            end
            STATE_WAIT: begin
               if (r_count == '0) begin
                  r_rspError <= w_error;
                  r_rspData  <= (w_error || r_req.write) ? 32'h0000_0000 : w_loadData;
                  r_state    <= STATE_RESPOND;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            STATE_RESPOND: begin
               if (rsp_ready_i) begin
                  r_state <= STATE_IDLE;
               end
            end
            default: r_state <= STATE_IDLE;
         endcase
      end
   end

   // Byte-enabled store port; the array is never cleared by reset.
   always_ff @(posedge clk_i) begin
      if (w_commitStore) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (w_byteEnable[lane]) begin
               r_mem[w_wordIndex][lane*8 +: 8] <= w_storeData[lane*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
// Directed bench for data_memory_responder: a vector table of loads/stores
// with hand-computed results on a WAIT_STATES=2 instance, plus backpressure,
// mid-transaction reset and back-to-back sequences; a WAIT_STATES=0
// instance covers zero-wait reset abort and throughput.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int NUM_VECTORS = 28;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  funct3;
      logic [31:0] expData;
      logic        expError;
   } vector_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, reqValid, reqReady, reqWrite, rspValid, rspReady, rspError, busy;
   logic [31:0] reqAddress, reqData, rspData;
   logic [2:0]  reqFunct3;

   logic        resetZ, reqValidZ, reqReadyZ, reqWriteZ, rspValidZ, rspReadyZ, rspErrorZ, busyZ;
   logic [31:0] reqAddressZ, reqDataZ, rspDataZ;
   logic [2:0]  reqFunct3Z;

   int errors = 0;
   int checks = 0;
   vector_t vectors [NUM_VECTORS];

   data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .INIT_FILE("")) dut (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(reqValid), .req_ready_o(reqReady), .req_write_i(reqWrite),
      .req_address_i(reqAddress), .req_data_i(reqData), .req_funct3_i(reqFunct3),
      .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData),
      .rsp_error_o(rspError), .busy_o(busy)
   );

   data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .INIT_FILE("")) dutZero (
      .clk_i(clk), .reset_i(resetZ),
      .req_valid_i(reqValidZ), .req_ready_o(reqReadyZ), .req_write_i(reqWriteZ),
      .req_address_i(reqAddressZ), .req_data_i(reqDataZ), .req_funct3_i(reqFunct3Z),
      .rsp_valid_o(rspValidZ), .rsp_ready_i(rspReadyZ), .rsp_data_o(rspDataZ),
      .rsp_error_o(rspErrorZ), .busy_o(busyZ)
   );

   // Single comparison point: every check funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Count edges from the accepting edge until rsp_valid rises (bounded).
   task automatic waitResponse(output int lat);
      lat = 0;
      while (!rspValid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic waitResponseZ(output int lat);
      lat = 0;
      while (!rspValidZ && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // One full transaction on the WAIT_STATES=2 instance with rsp_ready high.
   task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] f3, output logic [31:0] rdata,
                                output logic rerr, output int lat);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = write; reqAddress = addr; reqData = data;
      reqFunct3 = f3; rspReady = 1'b1;
      @(posedge clk); #1;
      reqValid = 1'b0;
      waitResponse(lat);
      rdata = rspData;
      rerr  = rspError;
      @(posedge clk); #1;
   endtask

   task automatic applyStimulusZ(input logic write, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] f3, output logic [31:0] rdata,
                                 output logic rerr, output int lat);
      @(negedge clk);
      reqValidZ = 1'b1; reqWriteZ = write; reqAddressZ = addr; reqDataZ = data;
      reqFunct3Z = f3; rspReadyZ = 1'b1;
      @(posedge clk); #1;
      reqValidZ = 1'b0;
      waitResponseZ(lat);
      rdata = rspDataZ;
      rerr  = rspErrorZ;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rdata;
      logic        rerr;
      int          lat;
      logic [5:0]  expValidPattern;
      logic [5:0]  expReadyPattern;

      vectors[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0};
      vectors[1]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0};
      vectors[2]  = '{1'b1, 32'h0000_0011, 32'h0000_00AA, 3'b000, 32'h0000_0000, 1'b0};
      vectors[3]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_AAEF, 1'b0};
      vectors[4]  = '{1'b0, 32'h0000_0011, 32'h0,         3'b000, 32'hFFFF_FFAA, 1'b0};
      vectors[5]  = '{1'b0, 32'h0000_0011, 32'h0,         3'b100, 32'h0000_00AA, 1'b0};
      vectors[6]  = '{1'b1, 32'h0000_0012, 32'h0000_8001, 3'b001, 32'h0000_0000, 1'b0};
      vectors[7]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b001, 32'hFFFF_8001, 1'b0};
      vectors[8]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b101, 32'h0000_8001, 1'b0};
      vectors[9]  = '{1'b0, 32'h0000_0013, 32'h0,         3'b001, 32'h0000_0000, 1'b1};
      vectors[10] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 3'b010, 32'h0000_0000, 1'b0};
      vectors[11] = '{1'b1, 32'h0000_1000, 32'h5555_5555, 3'b010, 32'h0000_0000, 1'b1};
      vectors[12] = '{1'b0, 32'h0000_0000, 32'h0,         3'b010, 32'h0BAD_F00D, 1'b0};
      vectors[13] = '{1'b0, 32'h0000_0010, 32'h0,         3'b011, 32'h0000_0000, 1'b1};
      vectors[14] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 3'b100, 32'h0000_0000, 1'b1};
      vectors[15] = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'h8001_AAEF, 1'b0};
      vectors[16] = '{1'b1, 32'h0000_0003, 32'h1234_56C3, 3'b000, 32'h0000_0000, 1'b0};
      vectors[17] = '{1'b0, 32'h0000_0000, 32'h0,         3'b010, 32'hC3AD_F00D, 1'b0};
      vectors[18] = '{1'b0, 32'h0000_0013, 32'h0,         3'b000, 32'hFFFF_FF80, 1'b0};
      vectors[19] = '{1'b0, 32'h0000_0012, 32'h0,         3'b100, 32'h0000_0001, 1'b0};
      vectors[20] = '{1'b0, 32'h0000_0016, 32'h0,         3'b010, 32'h0000_0000, 1'b1};
      vectors[21] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 3'b010, 32'h0000_0000, 1'b0};
      vectors[22] = '{1'b0, 32'h0000_0FFC, 32'h0,         3'b010, 32'hA5A5_A5A5, 1'b0};
      vectors[23] = '{1'b0, 32'h8000_0010, 32'h0,         3'b010, 32'h0000_0000, 1'b1};
      vectors[24] = '{1'b1, 32'h0000_0002, 32'hABCD_1234, 3'b001, 32'h0000_0000, 1'b0};
      vectors[25] = '{1'b0, 32'h0000_0000, 32'h0,         3'b010, 32'h1234_F00D, 1'b0};
      vectors[26] = '{1'b1, 32'h0000_0020, 32'h0000_C0DE, 3'b010, 32'h0000_0000, 1'b0};
      vectors[27] = '{1'b0, 32'h0000_0001, 32'h0,         3'b101, 32'h0000_0000, 1'b1};

      reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqData = '0;
      reqFunct3 = '0; rspReady = 1'b1;
      resetZ = 1'b1; reqValidZ = 1'b0; reqWriteZ = 1'b0; reqAddressZ = '0; reqDataZ = '0;
      reqFunct3Z = '0; rspReadyZ = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; resetZ = 1'b0;
      @(posedge clk); #1;
      $display("[TB] reset released");
      checkOutput("reset req_ready", 32'(reqReady), 32'd1);
      checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset rsp_data",  rspData, 32'd0);
      checkOutput("reset rsp_error", 32'(rspError), 32'd0);
      checkOutput("reset busy",      32'(busy), 32'd0);
      checkOutput("reset zero busy", 32'(busyZ), 32'd0);

      // Table-driven loads/stores on the two-wait-state instance.
      for (int i = 0; i < NUM_VECTORS; i++) begin
         applyStimulus(vectors[i].write, vectors[i].addr, vectors[i].data, vectors[i].funct3,
                       rdata, rerr, lat);
         checkOutput($sformatf("vec%0d data", i), rdata, vectors[i].expData);
         checkOutput($sformatf("vec%0d error", i), 32'(rerr), 32'(vectors[i].expError));
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      end

      // Backpressure: response held five cycles while a new request is offered.
      $display("[TB] backpressure sequence");
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 32'h10; reqFunct3 = 3'b010; rspReady = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b0;
      waitResponse(lat);
      checkOutput("bp latency", 32'(lat), 32'd3);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("bp valid %0d", k), 32'(rspValid), 32'd1);
         checkOutput($sformatf("bp data %0d", k), rspData, 32'h8001_AAEF);
         checkOutput($sformatf("bp req_ready %0d", k), 32'(reqReady), 32'd0);
         if (k == 1) begin
            reqValid = 1'b1; reqWrite = 1'b1; reqData = 32'hFFFF_FFFF; reqFunct3 = 3'b010;
         end
         if (k == 3) reqValid = 1'b0;
         @(posedge clk); #1;
      end
      rspReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp release valid", 32'(rspValid), 32'd0);
      checkOutput("bp release ready", 32'(reqReady), 32'd1);
      applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("bp ignored store", rdata, 32'h8001_AAEF);

      // Reset during WAIT of a store: aborted, not committed.
      $display("[TB] reset mid-transaction sequence");
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 32'h20; reqData = 32'h1234_5678;
      reqFunct3 = 3'b010; rspReady = 1'b1;
      @(posedge clk); #1;
      reqValid = 1'b0;
      checkOutput("abort busy before reset", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort req_ready", 32'(reqReady), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("abort no response %0d", k), 32'(rspValid), 32'd0);
      end
      applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("abort prior contents", rdata, 32'h0000_C0DE);
      checkOutput("abort load error", 32'(rerr), 32'd0);

      // Zero-wait instance: latency, reset on the access edge, back-to-back.
      $display("[TB] zero wait-state sequences");
      applyStimulusZ(1'b1, 32'h8, 32'h0000_AAAA, 3'b010, rdata, rerr, lat);
      checkOutput("zero store latency", 32'(lat), 32'd1);
      @(negedge clk);
      reqValidZ = 1'b1; reqWriteZ = 1'b1; reqAddressZ = 32'h8; reqDataZ = 32'hBBBB_BBBB;
      reqFunct3Z = 3'b010;
      @(posedge clk); #1;
      reqValidZ = 1'b0;
      resetZ = 1'b1;
      @(posedge clk); #1;
      resetZ = 1'b0;
      checkOutput("zero abort valid", 32'(rspValidZ), 32'd0);
      checkOutput("zero abort busy", 32'(busyZ), 32'd0);
      applyStimulusZ(1'b0, 32'h8, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("zero abort contents", rdata, 32'h0000_AAAA);
      checkOutput("zero load latency", 32'(lat), 32'd1);

      expValidPattern = 6'b010010;
      expReadyPattern = 6'b100100;
      @(negedge clk);
      reqValidZ = 1'b1; reqWriteZ = 1'b1; reqAddressZ = 32'h8; reqDataZ = 32'h1111_2222;
      reqFunct3Z = 3'b010; rspReadyZ = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("b2b valid %0d", k), 32'(rspValidZ), 32'(expValidPattern[k]));
         checkOutput($sformatf("b2b ready %0d", k), 32'(reqReadyZ), 32'(expReadyPattern[k]));
         if (k == 2) begin
            reqAddressZ = 32'hC; reqDataZ = 32'h3333_4444;
         end
         if (k == 3) reqValidZ = 1'b0;
      end
      applyStimulusZ(1'b0, 32'h8, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("b2b first word", rdata, 32'h1111_2222);
      applyStimulusZ(1'b0, 32'hC, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("b2b second word", rdata, 32'h3333_4444);
      applyStimulusZ(1'b1, 32'h100, 32'h0, 3'b010, rdata, rerr, lat);
      checkOutput("zero out of range error", 32'(rerr), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
